sdram_bus_tester: RTL and testbench

//  Built-in memory tester acting as system-bus master directly upstream of the SDRAM controller.

---
 rtl/sdram_bus_tester.sv | 163 ++++++++++++++++
 tb/tb_sdram_bus_tester.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bus_tester.sv
// sdram_bus_tester: built-in memory tester, bus master in front of the SDRAM
// controller. Writes a 16-bit LFSR pattern over BASE..BASE+NUM_WORDS-1,
// reads it back with up to MAX_OUT reads in flight, and compares each
// returned word against an independent copy of the LFSR.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               pulse, starts a test from IDLE or DONE
//   busy / done / pass  status; pass valid while done
//   err_count           saturating mismatch count
//   first_err_addr      word address of the first mismatch (0 if none)
//   bus_*               single-word request/response system bus
module sdram_bus_tester #(
  parameter int              DW        = 16,
  parameter int              AW        = 24,
  parameter logic [AW-1:0]   BASE      = '0,
  parameter int              NUM_WORDS = 1024,
  parameter logic [15:0]     SEED      = 16'hACE1,
  parameter int              MAX_OUT   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic          bus_read,
  output logic          bus_write,
  output logic [AW-1:0] bus_addr,
  output logic          bus_burst,
  output logic [2:0]    bus_burst_len,
  output logic [DW-1:0] bus_wdata,
  output logic [1:0]    bus_byteenable,
  input  logic          bus_ready,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  localparam int            CW    = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] LAST  = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [3:0]    MAX_L = 4'(MAX_OUT);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   wr_lfsr, exp_lfsr;
  logic [AW-1:0]   rd_addr;
  logic [CW-1:0]   cnt;
  logic [3:0]      outstanding;
  logic            go;
  logic            wr_acc, rd_acc, rv;

  // Fibonacci x^16+x^14+x^13+x^11+1 in right-shift form
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  assign bus_burst      = 1'b0;
  assign bus_burst_len  = 3'd0;
  assign bus_byteenable = 2'b11;
  assign pass           = done && (err_count == 16'd0);

  assign wr_acc = bus_write && bus_ready;
  assign rd_acc = bus_read && bus_ready;
  // a response with nothing in flight is stray and is not compared
  assign rv     = bus_rvalid && (outstanding != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    bus_write = 1'b0;
    bus_read  = 1'b0;
    case (state)
      IDLE: if (start) begin go = 1'b1; state_nxt = WRITE; end
      WRITE: begin
        busy      = 1'b1;
        bus_write = 1'b1;
        if (bus_ready && cnt == LAST) state_nxt = READ;
      end
      READ: begin
        busy     = 1'b1;
        bus_read = (outstanding < MAX_L);
        if (bus_read && bus_ready && cnt == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (outstanding == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin go = 1'b1; state_nxt = WRITE; end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_addr       <= '0;
      bus_wdata      <= '0;
      wr_lfsr        <= SEED;
      exp_lfsr       <= SEED;
      rd_addr        <= '0;
      cnt            <= '0;
      outstanding    <= 4'd0;
      err_count      <= 16'd0;
      first_err_addr <= '0;
    end else if (go) begin
      bus_addr       <= BASE;
      bus_wdata      <= SEED;
      wr_lfsr        <= SEED;
      exp_lfsr       <= SEED;
      rd_addr        <= BASE;
      cnt            <= '0;
      outstanding    <= 4'd0;
      err_count      <= 16'd0;
      first_err_addr <= '0;
    end else begin
      if (wr_acc) begin
        wr_lfsr   <= lfsr_next(wr_lfsr);
        bus_wdata <= lfsr_next(wr_lfsr);
        if (cnt == LAST) begin
          // reuse the same counter/address for the read pass
          cnt      <= '0;
          bus_addr <= BASE;
        end else begin
          cnt      <= cnt + ONE_C;
          bus_addr <= bus_addr + ONE_A;
        end
      end
      if (rd_acc) begin
        cnt      <= cnt + ONE_C;
        bus_addr <= bus_addr + ONE_A;
      end
      case ({rd_acc, rv})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      if (rv) begin
        exp_lfsr <= lfsr_next(exp_lfsr);
        rd_addr  <= rd_addr + ONE_A;
        if (bus_rdata != exp_lfsr) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          // count is saturating, so zero means no mismatch seen yet
          if (err_count == 16'd0) first_err_addr <= rd_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_bus_tester.sv
module tb_sdram_bus_tester;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic        rdy;
  always #5 clk = ~clk;

  // main DUT: BASE=0, 8 words, MAX_OUT=4
  logic        busy, done, pass, bus_read, bus_write, bus_burst, bus_rvalid;
  logic [15:0] err_count, bus_wdata, bus_rdata;
  logic [23:0] first_err_addr, bus_addr;
  logic [2:0]  bus_burst_len;
  logic [1:0]  bus_byteenable;

  sdram_bus_tester #(.BASE(24'h0), .NUM_WORDS(8), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_burst(bus_burst), .bus_burst_len(bus_burst_len), .bus_wdata(bus_wdata),
    .bus_byteenable(bus_byteenable), .bus_ready(rdy), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata));

  // second DUT: address wrap at the top of the 24-bit space
  logic        busy2, done2, pass2, read2, write2, burst2, rvalid2;
  logic [15:0] err2, wdata2, rdata2;
  logic [23:0] ferr2, addr2;
  logic [2:0]  blen2;
  logic [1:0]  be2;

  sdram_bus_tester #(.BASE(24'hFFFFFE), .NUM_WORDS(4), .MAX_OUT(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_addr(ferr2),
    .bus_read(read2), .bus_write(write2), .bus_addr(addr2),
    .bus_burst(burst2), .bus_burst_len(blen2), .bus_wdata(wdata2),
    .bus_byteenable(be2), .bus_ready(1'b1), .bus_rvalid(rvalid2),
    .bus_rdata(rdata2));

  // slave model for dut: in-order responses rd_delay cycles after accept
  typedef struct { int due; logic [15:0] d; } rsp_t;
  rsp_t        rq[$];
  rsp_t        rnew;
  logic [15:0] mem [0:255];
  logic [15:0] mem2 [0:3];
  logic [23:0] wa_log[$], ra_log[$], wa2_log[$];
  logic [15:0] wd_log[$];
  int          cyc = 0, outst = 0, max_outst = 0;
  int          rd_delay = 3, corrupt_addr = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rq.delete();
      outst = 0;
      bus_rvalid <= 1'b0;
      bus_rdata  <= 16'h0;
    end else begin
      cyc++;
      if (bus_rvalid) outst--;
      if (bus_write && rdy) begin
        mem[bus_addr[7:0]] = bus_wdata;
        wa_log.push_back(bus_addr);
        wd_log.push_back(bus_wdata);
      end
      if (bus_read && rdy) begin
        rnew.due = cyc + rd_delay;
        rnew.d   = mem[bus_addr[7:0]] ^ ((int'(bus_addr) == corrupt_addr) ? 16'h0001 : 16'h0000);
        rq.push_back(rnew);
        ra_log.push_back(bus_addr);
        outst++;
        if (outst > max_outst) max_outst = outst;
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        bus_rvalid <= 1'b1;
        bus_rdata  <= rq[0].d;
        void'(rq.pop_front());
      end else begin
        bus_rvalid <= 1'b0;
      end
    end
  end

  // slave for dut2: always ready, data back next cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid2 <= 1'b0;
      rdata2  <= 16'h0;
    end else begin
      if (write2) begin
        mem2[addr2[1:0]] = wdata2;
        wa2_log.push_back(addr2);
      end
      rvalid2 <= read2;
      if (read2) rdata2 <= mem2[addr2[1:0]];
    end
  end

  int checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic clear_logs();
    wa_log.delete(); wd_log.delete(); ra_log.delete();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_writes(input int k, input string tag);
    int n = 0;
    while (wa_log.size() < k && n < 500) begin @(negedge clk); n++; end
    chk(tag, wa_log.size(), k);
  endtask

  // whole write/read pass of dut covered addresses 0..7 once each, in order,
  // with the LFSR pattern starting at SEED
  task automatic chk_logs(input string tag);
    logic [15:0] m = 16'hACE1;
    int bad = 0;
    chk({tag, "_nwr"}, wa_log.size(), 8);
    chk({tag, "_nrd"}, ra_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wa_log.size() && (wa_log[i] !== 24'(i) || wd_log[i] !== m)) bad++;
      if (i < ra_log.size() && ra_log[i] !== 24'(i)) bad++;
      m = lfsr_step(m);
    end
    chk({tag, "_seq"}, bad, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; rdy = 1'b1;
    #3;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pass", {31'd0, pass}, 0);
    chk("rst_cmd",  {30'd0, bus_read, bus_write}, 0);
    chk("rst_err",  err_count, 0);
    chk("rst_ferr", first_err_addr, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("tie_be",   {29'd0, bus_burst, bus_byteenable}, 32'h3);
    @(negedge clk); rst = 1'b0;

    // 1: ideal slave
    clear_logs();
    pulse_start();
    chk("t1_first_write", {7'd0, bus_write, bus_addr}, 32'h0100_0000);
    chk("t1_first_wdata", bus_wdata, 16'hACE1);
    chk("t1_busy", {31'd0, busy}, 1);
    @(negedge clk);
    chk("t1_second_wdata", bus_wdata, 16'h5670);
    chk("t1_second_addr", bus_addr, 24'h1);
    wait_done("t1_done");
    chk("t1_pass", {31'd0, pass}, 1);
    chk("t1_err", err_count, 0);
    chk_logs("t1");
    repeat (3) @(negedge clk);
    chk("t1_done_held", {30'd0, done, busy}, 32'h2);

    // 2: word 5 corrupted
    corrupt_addr = 5;
    pulse_start();
    chk("t2_cleared", {15'd0, done, err_count}, 0);
    wait_done("t2_done");
    chk("t2_pass", {31'd0, pass}, 0);
    chk("t2_err", err_count, 1);
    chk("t2_ferr", first_err_addr, 24'h5);
    corrupt_addr = -1;

    // 3: ready low for 4 cycles mid-write
    clear_logs();
    pulse_start();
    wait_writes(3, "t3_wait3");
    rdy = 1'b0;
    chk("t3_hold_addr", bus_addr, 24'h3);
    chk("t3_hold_wdata", bus_wdata, 16'hAB38 >> 0 ^ 16'h0 ^ 16'h0 ^ 16'h0 ^ 16'h0 ^ lfsr_step(16'hAB38) ^ 16'hAB38);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_stable", {7'd0, bus_write, bus_addr}, 32'h0100_0003);
    end
    chk("t3_no_accept", wa_log.size(), 3);
    rdy = 1'b1;
    wait_done("t3_done");
    chk("t3_pass", {31'd0, pass}, 1);
    chk_logs("t3");

    // 4: slow slave, outstanding bounded; start while busy ignored
    rd_delay = 20; max_outst = 0;
    clear_logs();
    pulse_start();
    repeat (15) @(negedge clk);
    chk("t4_in_read", {31'd0, bus_read | busy}, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done("t4_done");
    chk("t4_max_out", max_outst, 4);
    chk("t4_pass", {31'd0, pass}, 1);
    chk_logs("t4");
    rd_delay = 3;

    // 5: address wrap on dut2
    wa2_log.delete();
    @(negedge clk); start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    begin
      int n = 0;
      while (!done2 && n < 500) begin @(negedge clk); n++; end
    end
    chk("t5_done", {31'd0, done2}, 1);
    chk("t5_pass", {31'd0, pass2}, 1);
    chk("t5_nwr", wa2_log.size(), 4);
    if (wa2_log.size() == 4) begin
      chk("t5_a0", wa2_log[0], 24'hFFFFFE);
      chk("t5_a1", wa2_log[1], 24'hFFFFFF);
      chk("t5_a2", wa2_log[2], 24'h000000);
      chk("t5_a3", wa2_log[3], 24'h000001);
    end

    // 6: reset during the third write
    clear_logs();
    pulse_start();
    wait_writes(2, "t6_wait2");
    rst = 1'b1;
    #1;
    chk("t6_rst_out", {29'd0, busy, bus_write, bus_read}, 0);
    chk("t6_rst_addr", bus_addr, 0);
    chk("t6_rst_wdata", bus_wdata, 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_quiet", {29'd0, busy, bus_write, bus_read}, 0);
    chk("t6_nwr_after", wa_log.size(), 2);
    clear_logs();
    pulse_start();
    wait_done("t6_done");
    chk("t6_pass", {31'd0, pass}, 1);
    chk_logs("t6");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
